// File: rtl/as_pack.sv
// rtl/as_pack.sv - shared constants, opcodes and ALU operation type for the as_top_mem RV64I subsystem
package as_pack;
    localparam int nr_gpios        = 32;
    localparam int gpio_addr_width = 8;
    localparam int im_scan_length  = 32;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    localparam logic [2:0] F3_LB   = 3'd0;
    localparam logic [2:0] F3_LH   = 3'd1;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_LD   = 3'd3;
    localparam logic [2:0] F3_LBU  = 3'd4;
    localparam logic [2:0] F3_LHU  = 3'd5;
    localparam logic [2:0] F3_LWU  = 3'd6;

    localparam logic [15:0] DMEM_BASE     = 16'h4000;
    localparam logic [15:0] GPIO_BASE     = 16'h8000;
    localparam logic [7:0]  GPIO_DATA_OFS = 8'h04;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    // alt selects SUB/SRA; callers must only raise it where funct7 is meaningful
    function automatic alu_op_t f3_to_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/as_alu.sv
// rtl/as_alu.sv - 64-bit integer ALU with 32-bit word-op mode
module as_alu
    import as_pack::*;
(
    input  alu_op_t     op_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        word_i,
    output logic [63:0] y_o
);
    logic [5:0]  shamt;
    logic [63:0] a_sx;
    logic [63:0] r;

    always_comb begin
        shamt = word_i ? {1'b0, b_i[4:0]} : b_i[5:0];
        a_sx  = word_i ? {{32{a_i[31]}}, a_i[31:0]} : a_i;
        r     = '0;
        case (op_i)
            ALU_ADD:  r = a_i + b_i;
            ALU_SUB:  r = a_i - b_i;
            ALU_SLL:  r = a_i << shamt;
            ALU_SLT:  r = {63'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: r = {63'b0, a_i < b_i};
            ALU_XOR:  r = a_i ^ b_i;
            ALU_SRL:  r = (word_i ? {32'b0, a_i[31:0]} : a_i) >> shamt;
            ALU_SRA:  r = $signed(a_sx) >>> shamt;
            ALU_OR:   r = a_i | b_i;
            ALU_AND:  r = a_i & b_i;
            default:  r = '0;
        endcase
        // word ops only produce a meaningful low half; widen it by sign
        y_o = word_i ? {{32{r[31]}}, r[31:0]} : r;
    end
endmodule

// File: rtl/as_top_mem.sv
// rtl/as_top_mem.sv - single-cycle RV64I core with instruction ROM, data RAM and GPIO output register
module as_top_mem
    import as_pack::*;
#(
    parameter int    IMEM_WORDS  = 1024,
    parameter int    DMEM_DWORDS = 512,
    parameter string IMEM_FILE   = "imem.hex"
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tck_i,
    input  logic                trst_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    output logic                tdo_o,
    inout  wire [nr_gpios-1:0]  gpio_io,
    output logic                cs_o
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_DWORDS);

    logic [31:0]         imem [0:IMEM_WORDS-1];
    logic [63:0]         dmem [0:DMEM_DWORDS-1];
    logic [63:0]         rf_q [0:31];
    logic [63:0]         pc_q, pc_d;
    logic [nr_gpios-1:0] gpio_q, gpio_d;
    logic                cs_q, cs_d;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1v, rs2v, pc_plus4;

    assign instr    = imem[pc_q[IW+1:2]];
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign imm_i    = {{52{instr[31]}}, instr[31:20]};
    assign imm_s    = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j    = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign rs1v     = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2v     = (rs2 == 5'd0) ? '0 : rf_q[rs2];
    assign pc_plus4 = pc_q + 64'd4;

    alu_op_t     alu_op;
    logic [63:0] alu_a, alu_b, alu_y;
    logic        alu_word;

    // the ALU also forms load/store addresses and the JALR target
    always_comb begin
        alu_a    = rs1v;
        alu_b    = imm_i;
        alu_op   = ALU_ADD;
        alu_word = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP32: begin
                alu_b    = rs2v;
                alu_op   = f3_to_alu_op(f3, instr[30]);
                alu_word = (opcode == OPC_OP32);
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                alu_op   = f3_to_alu_op(f3, (f3 == F3_SR) && instr[30]);
                alu_word = (opcode == OPC_OPIMM32);
            end
            OPC_STORE: alu_b = imm_s;
            OPC_AUIPC: begin alu_a = pc_q; alu_b = imm_u; end
            OPC_LUI:   begin alu_a = '0;   alu_b = imm_u; end
            default: ;
        endcase
    end

    as_alu u_alu (.op_i(alu_op), .a_i(alu_a), .b_i(alu_b), .word_i(alu_word), .y_o(alu_y));

    logic [15:0] mem_addr;
    logic [2:0]  byte_off;
    logic        is_ram, gpio_hit, is_store;
    logic [63:0] ram_rd, ld_raw, ld_val, st_data;
    logic [7:0]  st_mask;

    assign mem_addr = alu_y[15:0];
    assign byte_off = mem_addr[2:0];
    assign is_ram   = mem_addr[15:14] == DMEM_BASE[15:14];
    assign gpio_hit = (mem_addr[15:8] == GPIO_BASE[15:8])
                   && (mem_addr[gpio_addr_width-1:0] == GPIO_DATA_OFS);
    assign is_store = opcode == OPC_STORE;
    assign ram_rd   = dmem[mem_addr[DW+2:3]];
    assign st_data  = rs2v << {byte_off, 3'b000};

    always_comb begin
        ld_raw = '0;
        if (is_ram)        ld_raw = ram_rd >> {byte_off, 3'b000};
        else if (gpio_hit) ld_raw = 64'(gpio_q);
        case (f3)
            F3_LB:   ld_val = {{56{ld_raw[7]}},  ld_raw[7:0]};
            F3_LH:   ld_val = {{48{ld_raw[15]}}, ld_raw[15:0]};
            F3_LW:   ld_val = {{32{ld_raw[31]}}, ld_raw[31:0]};
            F3_LD:   ld_val = ld_raw;
            F3_LBU:  ld_val = {56'b0, ld_raw[7:0]};
            F3_LHU:  ld_val = {48'b0, ld_raw[15:0]};
            F3_LWU:  ld_val = {32'b0, ld_raw[31:0]};
            default: ld_val = ld_raw;
        endcase
        case (f3[1:0])
            2'd0:    st_mask = 8'h01 << byte_off;
            2'd1:    st_mask = 8'h03 << byte_off;
            2'd2:    st_mask = 8'h0F << byte_off;
            default: st_mask = 8'hFF << byte_off;
        endcase
    end

    logic        rf_we, br_taken;
    logic [63:0] wb_data;

    always_comb begin
        rf_we    = 1'b0;
        wb_data  = alu_y;
        br_taken = 1'b0;
        pc_d     = pc_plus4;
        gpio_d   = gpio_q;
        cs_d     = 1'b0;
        case (f3)
            F3_BEQ:  br_taken = rs1v == rs2v;
            F3_BNE:  br_taken = rs1v != rs2v;
            F3_BLT:  br_taken = $signed(rs1v) <  $signed(rs2v);
            F3_BGE:  br_taken = $signed(rs1v) >= $signed(rs2v);
            F3_BLTU: br_taken = rs1v <  rs2v;
            F3_BGEU: br_taken = rs1v >= rs2v;
            default: br_taken = 1'b0;
        endcase
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM, OPC_OP32, OPC_OPIMM32: rf_we = 1'b1;
            OPC_LOAD: begin rf_we = 1'b1; wb_data = ld_val; end
            OPC_JAL:  begin rf_we = 1'b1; wb_data = pc_plus4; pc_d = pc_q + imm_j; end
            OPC_JALR: begin rf_we = 1'b1; wb_data = pc_plus4; pc_d = {alu_y[63:1], 1'b0}; end
            OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
            default: ;
        endcase
        if (is_store && gpio_hit) begin
            gpio_d = rs2v[nr_gpios-1:0];
            cs_d   = 1'b1;
        end
        rf_we = rf_we && (rd != 5'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q   <= '0;
            gpio_q <= '0;
            cs_q   <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            gpio_q <= gpio_d;
            cs_q   <= cs_d;
            if (rf_we) rf_q[rd] <= wb_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && is_store && is_ram) begin
            for (int b = 0; b < 8; b++)
                if (st_mask[b]) dmem[mem_addr[DW+2:3]][8*b +: 8] <= st_data[8*b +: 8];
        end
    end

    assign gpio_io = gpio_q;
    assign cs_o    = cs_q;
    assign tdo_o   = 1'b0;

    wire unused_jtag = &{1'b0, tck_i, trst_i, tms_i, tdi_i, 1'b0};
endmodule

// File: tb/tb_as_top_mem.sv
// tb/tb_as_top_mem.sv - directed program tests for as_top_mem
module tb_as_top_mem;
    import as_pack::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic tck_i = 1'b0, trst_i = 1'b0, tms_i = 1'b0, tdi_i = 1'b0;
    wire                tdo_w;
    wire                cs_w;
    wire [nr_gpios-1:0] gpio_w;

    int total = 0;
    int bad   = 0;
    logic [31:0] prog[$];
    logic [31:0] obs[$];
    logic [31:0] exp_q[$];

    as_top_mem #(.IMEM_WORDS(1024), .DMEM_DWORDS(512), .IMEM_FILE("")) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tck_i(tck_i), .trst_i(trst_i),
        .tms_i(tms_i), .tdi_i(tdi_i), .tdo_o(tdo_w), .gpio_io(gpio_w), .cs_o(cs_w)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] opc);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, logic [6:0] opc);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], opc};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], OPC_STORE};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], OPC_BRANCH};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] opc);
        return {imm20[19:0], rd[4:0], opc};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OPC_JAL};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 64; i++)
            dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
    endtask

    task automatic start();
        rst_i = 1'b1;
        load_prog();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic run_collect(input int n);
        obs.delete();
        repeat (n) begin
            @(negedge clk_i);
            if (cs_w === 1'b1) obs.push_back(gpio_w);
        end
    endtask

    // addi x1,1 ; slli x2,x1,2 ; lui x5,8 ; sw x2,4(x5) ; sw x1,4(x5) ; loop
    task automatic set_slli_prog();
        prog = {enc_i(1, 0, 0, 1, OPC_OPIMM), enc_i(2, 1, 1, 2, OPC_OPIMM),
                enc_u(8, 5, OPC_LUI), enc_s(4, 2, 5, 2), enc_s(4, 1, 5, 2), enc_j(0, 0)};
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        set_slli_prog();
        load_prog();
        repeat (10) @(negedge clk_i);
        total++; if (cs_w !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b want=0", cs_w); end
        total++; if (gpio_w !== 32'h0) begin bad++; $display("FAIL reset_gpio got=%h want=0", gpio_w); end
        total++; if (dut.pc_q !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", dut.pc_q); end
        total++; if (tdo_w !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b want=0", tdo_w); end
        rst_i = 1'b0;
        @(negedge clk_i);
        total++; if (dut.pc_q !== 64'h4) begin bad++; $display("FAIL first_fetch_pc got=%h want=4", dut.pc_q); end
        total++; if (dut.rf_q[1] !== 64'h1) begin bad++; $display("FAIL first_fetch_x1 got=%h want=1", dut.rf_q[1]); end
    endtask

    task automatic test_slli();
        set_slli_prog();
        start();
        run_collect(20);
        exp_q = {32'h4, 32'h1};
        total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL slli_count got=%0d want=%0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL slli_gpio[%0d] got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_slli64();
        prog = {enc_i(1, 0, 0, 1, OPC_OPIMM), enc_i(63, 1, 1, 2, OPC_OPIMM),
                enc_i(63, 2, 5, 3, OPC_OPIMM), enc_u(8, 5, OPC_LUI),
                enc_i(32, 2, 5, 4, OPC_OPIMM), enc_s(4, 4, 5, 2), enc_s(4, 3, 5, 2), enc_j(0, 0)};
        start();
        run_collect(20);
        total++; if (dut.rf_q[2] !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL slli64_x2 got=%h want=8000000000000000", dut.rf_q[2]); end
        exp_q = {32'h8000_0000, 32'h1};
        total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL slli64_count got=%0d want=%0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL slli64_gpio[%0d] got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_slliw();
        prog = {enc_u(32'h40000, 1, OPC_LUI), enc_i(1, 1, 1, 2, OPC_OPIMM32),
                enc_i(32'h420, 2, 5, 3, OPC_OPIMM), enc_u(8, 5, OPC_LUI),
                enc_s(4, 3, 5, 2), enc_s(4, 2, 5, 2), enc_j(0, 0)};
        start();
        run_collect(20);
        total++; if (dut.rf_q[2] !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL slliw_x2 got=%h want=ffffffff80000000", dut.rf_q[2]); end
        exp_q = {32'hFFFF_FFFF, 32'h8000_0000};
        total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL slliw_count got=%0d want=%0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL slliw_gpio[%0d] got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    // any mismatch branches to word 21, which reports 0xFF
    task automatic test_ldst_branch();
        prog = {enc_u(8, 5, OPC_LUI), enc_u(4, 6, OPC_LUI),
                enc_u(32'h12345, 1, OPC_LUI), enc_i(32'h678, 1, 0, 1, OPC_OPIMM),
                enc_i(32, 1, 1, 7, OPC_OPIMM), enc_r(0, 7, 1, 6, 1, OPC_OP),
                enc_s(0, 1, 6, 3), enc_i(0, 6, 3, 2, OPC_LOAD), enc_b(52, 2, 1, 1),
                enc_i(-128, 0, 0, 8, OPC_OPIMM), enc_s(9, 8, 6, 0), enc_i(9, 6, 0, 9, OPC_LOAD),
                enc_b(36, 9, 8, 1),
                enc_i(9, 6, 4, 10, OPC_LOAD), enc_i(128, 0, 0, 11, OPC_OPIMM), enc_b(24, 11, 10, 1),
                enc_i(4, 0, 0, 3, OPC_OPIMM), enc_s(4, 3, 5, 2),
                enc_i(1, 0, 0, 3, OPC_OPIMM), enc_s(4, 3, 5, 2), enc_j(0, 0),
                enc_i(255, 0, 0, 3, OPC_OPIMM), enc_s(4, 3, 5, 2), enc_j(0, 0)};
        start();
        run_collect(40);
        total++; if (dut.rf_q[2] !== 64'h1234_5678_1234_5678) begin bad++; $display("FAIL ld_x2 got=%h want=1234567812345678", dut.rf_q[2]); end
        exp_q = {32'h4, 32'h1};
        total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL ldst_count got=%0d want=%0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL ldst_gpio[%0d] got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit found;
        prog = {enc_i(1, 0, 0, 1, OPC_OPIMM), enc_i(2, 1, 1, 2, OPC_OPIMM),
                enc_u(8, 5, OPC_LUI), enc_s(4, 2, 5, 2),
                32'h13, 32'h13, 32'h13, 32'h13, enc_s(4, 1, 5, 2), enc_j(0, 0)};
        start();
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk_i);
            if (cs_w === 1'b1) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL midrst_first_pulse got=timeout want=pulse"); end
        total++; if (gpio_w !== 32'h4) begin bad++; $display("FAIL midrst_first_gpio got=%h want=4", gpio_w); end
        rst_i = 1'b1;
        @(negedge clk_i);
        total++; if (gpio_w !== 32'h0) begin bad++; $display("FAIL midrst_gpio got=%h want=0", gpio_w); end
        total++; if (dut.pc_q !== 64'h0) begin bad++; $display("FAIL midrst_pc got=%h want=0", dut.pc_q); end
        for (int c = 0; c < 3; c++) begin
            total++; if (cs_w !== 1'b0) begin bad++; $display("FAIL midrst_cs[%0d] got=%b want=0", c, cs_w); end
            if (c < 2) @(negedge clk_i);
        end
        rst_i = 1'b0;
        run_collect(30);
        exp_q = {32'h4, 32'h1};
        total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_gpio[%0d] got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_slli();
        test_slli64();
        test_slliw();
        test_ldst_branch();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
